// File: rtl/mnist_pkg.sv
// Shared types and widths for the MNIST datapath stages.
// Optional macro FC2_LOGIT_WR_EN widens the fc2 interface with a logit write port.
package mnist_pkg;

  localparam int IN_DIM_D  = 32;
  localparam int OUT_DIM_D = 10;
  localparam int ACC_W     = 32;
  localparam int DATA_W    = 8;
  localparam int PROD_W    = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_CMP,
    S_DONE
  } fc2_state_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(
    input logic signed [PROD_W-1:0] p
  );
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fc2_argmax_if.sv
// Control, memory-read and result bundle for fc2_argmax.
// FC2_LOGIT_WR_EN adds the per-neuron logit write port.
interface fc2_argmax_if
  import mnist_pkg::*;
#(
  parameter int IN_DIM  = IN_DIM_D,
  parameter int OUT_DIM = OUT_DIM_D
);
  localparam int HW = $clog2(IN_DIM);
  localparam int WW = $clog2(IN_DIM * OUT_DIM);
  localparam int BW = $clog2(OUT_DIM);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [HW-1:0]            h_addr;
  logic signed [DATA_W-1:0] h_data;
  logic [WW-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic [BW-1:0]            b_addr;
  logic signed [ACC_W-1:0]  b_data;
  logic [BW-1:0]            class_out;
  logic signed [ACC_W-1:0]  max_logit;
`ifdef FC2_LOGIT_WR_EN
  logic                     logit_we;
  logic [BW-1:0]            logit_addr;
  logic signed [ACC_W-1:0]  logit_data;
`endif

  modport master (
    input  start, h_data, w_data, b_data,
    output busy, done, h_addr, w_addr, b_addr,
    output class_out, max_logit
`ifdef FC2_LOGIT_WR_EN
    , output logit_we, logit_addr, logit_data
`endif
  );

  modport slave (
    output start, h_data, w_data, b_data,
    input  busy, done, h_addr, w_addr, b_addr,
    input  class_out, max_logit
`ifdef FC2_LOGIT_WR_EN
    , input logit_we, logit_addr, logit_data
`endif
  );

endinterface

// File: rtl/fc2_argmax_tracker.sv
// Running signed maximum with index; ties keep the earlier index.
module argmax_tracker
  import mnist_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int VAL_W = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [VAL_W-1:0] value,
  output logic [IDX_W-1:0]        best_idx,
  output logic signed [VAL_W-1:0] best
);

  logic first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first    <= 1'b1;
      best_idx <= '0;
      best     <= '0;
    end else if (clear) begin
      first <= 1'b1;
    end else if (valid && (first || value > best)) begin
      first    <= 1'b0;
      best_idx <= idx;
      best     <= value;
    end
  end

endmodule

// File: rtl/fc2_argmax.sv
// Serial FC2 layer: bias + MAC per neuron, then argmax over the logits.
// FC2_LOGIT_WR_EN exports each finished logit during its compare cycle.
module fc2_argmax
  import mnist_pkg::*;
#(
  parameter int IN_DIM  = IN_DIM_D,
  parameter int OUT_DIM = OUT_DIM_D
) (
  input logic          clk,
  input logic          rst_n,
  fc2_argmax_if.master bus
);

  localparam int HW = $clog2(IN_DIM);
  localparam int WW = $clog2(IN_DIM * OUT_DIM);
  localparam int BW = $clog2(OUT_DIM);
  localparam logic [HW-1:0] K_LAST = HW'(IN_DIM - 1);
  localparam logic [BW-1:0] J_LAST = BW'(OUT_DIM - 1);

  fc2_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic [HW-1:0]            k;
  logic [BW-1:0]            j;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [BW-1:0]            best_idx;
  logic signed [ACC_W-1:0]  best;
  logic                     trk_clear;
  logic                     trk_valid;

  assign prod      = bus.w_data * bus.h_data;
  assign acc_nxt   = acc + sext_prod(prod);
  assign trk_clear = (state == S_IDLE) && bus.start;
  assign trk_valid = (state == S_CMP);

  argmax_tracker #(
    .IDX_W (BW),
    .VAL_W (ACC_W)
  ) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (trk_clear),
    .valid    (trk_valid),
    .idx      (j),
    .value    (acc),
    .best_idx (best_idx),
    .best     (best)
  );

  // Row-major W2 makes the next weight always w_addr+1,
  // including the hop from one neuron's row to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      k             <= '0;
      j             <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.h_addr    <= '0;
      bus.w_addr    <= '0;
      bus.b_addr    <= '0;
      bus.class_out <= '0;
      bus.max_logit <= '0;
`ifdef FC2_LOGIT_WR_EN
      bus.logit_we   <= 1'b0;
      bus.logit_addr <= '0;
      bus.logit_data <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef FC2_LOGIT_WR_EN
      bus.logit_we <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            j          <= '0;
            bus.b_addr <= '0;
            bus.h_addr <= '0;
            bus.w_addr <= '0;
            bus.busy   <= 1'b1;
            state      <= S_BIAS;
          end
        end
        S_BIAS: begin
          acc   <= bus.b_data;
          k     <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (k == K_LAST) begin
            state <= S_CMP;
`ifdef FC2_LOGIT_WR_EN
            bus.logit_we   <= 1'b1;
            bus.logit_addr <= j;
            bus.logit_data <= acc_nxt;
`endif
          end else begin
            k          <= k + 1'b1;
            bus.h_addr <= k + 1'b1;
            bus.w_addr <= bus.w_addr + WW'(1);
          end
        end
        S_CMP: begin
          if (j == J_LAST) begin
            state <= S_DONE;
          end else begin
            j          <= j + 1'b1;
            bus.b_addr <= j + 1'b1;
            bus.h_addr <= '0;
            bus.w_addr <= bus.w_addr + WW'(1);
            state      <= S_BIAS;
          end
        end
        S_DONE: begin
          bus.class_out <= best_idx;
          bus.max_logit <= best;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc2_argmax.sv
// Self-checking bench for fc2_argmax: vector table plus scoreboard.
module tb_fc2_argmax;
  import mnist_pkg::*;

  localparam int IN_DIM  = 32;
  localparam int OUT_DIM = 10;
  localparam int LAT     = OUT_DIM * (IN_DIM + 2) + 1;

  logic clk;
  logic rst_n;

  fc2_argmax_if #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) bus ();

  fc2_argmax #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [7:0]  h_mem [0:IN_DIM-1];
  logic signed [7:0]  w_mem [0:IN_DIM*OUT_DIM-1];
  logic signed [31:0] b_mem [0:OUT_DIM-1];

  always_comb begin
    bus.h_data = h_mem[bus.h_addr];
    bus.w_data = w_mem[bus.w_addr];
    bus.b_data = b_mem[bus.b_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [7:0] h_val;
    int                b_base;
    int                b_step;
    int                sp_idx;
    int                sp_val;
    int                w_row;
    logic signed [7:0] w_val;
    int                exp_class;
    int                exp_max;
    int                chk_idx;
    int                chk_logit;
  } vec_t;

  typedef struct {
    int     cls;
    int     mx;
    longint s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("class_out", longint'(bus.class_out), e.cls);
        chk("max_logit", longint'(bus.max_logit), e.mx);
        chk("latency", cyc - e.s, LAT);
      end
    end
  end

`ifdef FC2_LOGIT_WR_EN
  logic signed [31:0] logit_seen [0:OUT_DIM-1];
  always @(negedge clk) begin
    if (rst_n && bus.logit_we === 1'b1)
      logit_seen[bus.logit_addr] = bus.logit_data;
  end
`endif

  task automatic load(input vec_t v);
    for (int i = 0; i < IN_DIM; i++) h_mem[i] = v.h_val;
    for (int j = 0; j < OUT_DIM; j++) begin
      b_mem[j] = (j == v.sp_idx) ? v.sp_val : v.b_base + v.b_step * j;
      for (int i = 0; i < IN_DIM; i++)
        w_mem[j*IN_DIM+i] = (j == v.w_row) ? v.w_val : 8'sd0;
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < LAT + 50; i++) begin
      @(negedge clk);
      if (n_done > d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int d0;
    load(v);
    d0 = n_done;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    exp_q.push_back('{cls: v.exp_class, mx: v.exp_max, s: cyc});
    wait_done(d0, name);
`ifdef FC2_LOGIT_WR_EN
    if (v.chk_idx >= 0)
      chk({name, "_logit"}, longint'(logit_seen[v.chk_idx]), v.chk_logit);
`endif
  endtask

  vec_t vecs [7];

  initial begin
    longint s0;
    int     d0;

    vecs[0] = '{h_val: 0, b_base: 0, b_step: 0, sp_idx: 3, sp_val: 5,
                w_row: -1, w_val: 0, exp_class: 3, exp_max: 5,
                chk_idx: 3, chk_logit: 5};
    vecs[1] = '{h_val: 0, b_base: 7, b_step: 0, sp_idx: -1, sp_val: 0,
                w_row: -1, w_val: 0, exp_class: 0, exp_max: 7,
                chk_idx: -1, chk_logit: 0};
    vecs[2] = '{h_val: 1, b_base: 0, b_step: 0, sp_idx: -1, sp_val: 0,
                w_row: 9, w_val: 2, exp_class: 9, exp_max: 64,
                chk_idx: 9, chk_logit: 64};
    vecs[3] = '{h_val: 0, b_base: -100, b_step: -1, sp_idx: -1, sp_val: 0,
                w_row: -1, w_val: 0, exp_class: 0, exp_max: -100,
                chk_idx: 9, chk_logit: -109};
    vecs[4] = '{h_val: 127, b_base: 0, b_step: 0, sp_idx: -1, sp_val: 0,
                w_row: 5, w_val: -128, exp_class: 0, exp_max: 0,
                chk_idx: 5, chk_logit: -520192};
    vecs[5] = '{h_val: 3, b_base: -200, b_step: 0, sp_idx: 6, sp_val: -50,
                w_row: 2, w_val: -1, exp_class: 6, exp_max: -50,
                chk_idx: 2, chk_logit: -296};
    vecs[6] = '{h_val: 1, b_base: -5, b_step: 0, sp_idx: 1,
                sp_val: 2147483647, w_row: 1, w_val: 1,
                exp_class: 0, exp_max: -5,
                chk_idx: 1, chk_logit: -2147483617};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    load(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_class", bus.class_out, 0);
    chk("rst_max", bus.max_logit, 0);
    chk("rst_haddr", bus.h_addr, 0);
    chk("rst_waddr", bus.w_addr, 0);
    chk("rst_baddr", bus.b_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a run in neuron 4's MAC phase with a one-cycle reset.
    run_vec(vecs[2], "pre_reset");
    load(vecs[0]);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_class", bus.class_out, 0);
    chk("mid_rst_max", bus.max_logit, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk) rst_n = 1'b1;
    d0 = n_done;
    repeat (LAT + 20) @(negedge clk);
    chk("no_done_after_rst", n_done - d0, 0);
    run_vec(vecs[0], "post_reset");

    // Held start: run two begins the cycle after run one's done.
    d0 = n_done;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    s0 = cyc;
    exp_q.push_back('{cls: 3, mx: 5, s: s0});
    exp_q.push_back('{cls: 3, mx: 5, s: s0 + LAT + 1});
    repeat (398) @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    chk("busy_run2", bus.busy, 1);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (2 * LAT + 50 - 500) @(negedge clk);
    chk("held_done_count", n_done - d0, 2);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc2_argmax.md
Name: fc2_argmax

Overview:
- Output stage of the MNIST datapath, directly downstream of the first hidden FC layer.
- Serially computes OUT_DIM int32 logits as logit[j] = b2[j] + sum over k of W2[j*IN_DIM+k] * h1[k].
- Tracks the running maximum logit and reports the winning class index with a one-cycle done pulse.
- Reads the int8 hidden vector from the h1 memory; h1 values are non-negative because the previous stage applies ReLU.

Parameters:
- IN_DIM, 32: hidden vector length (h1 entries per neuron).
- OUT_DIM, 10: number of classes / output neurons.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  pulse; begins inference when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; class_out and max_logit valid on that cycle.
- h_addr  out  $clog2(IN_DIM)  h1 read address.
- h_data  in  8 signed  h1 read data.
- w_addr  out  $clog2(IN_DIM*OUT_DIM)  W2 read address, row-major.
- w_data  in  8 signed  W2 read data.
- b_addr  out  $clog2(OUT_DIM)  b2 read address.
- b_data  in  32 signed  b2 read data.
- class_out  out  $clog2(OUT_DIM)  predicted digit; held until the next done.
- max_logit  out  32 signed  winning logit; held until the next done.

Behaviour:
- Reset: state IDLE. busy, done, h_addr, w_addr, b_addr, class_out and max_logit all reset to 0. Internal acc, best, j and k reset to 0.
- Read model:
  - All addresses are registered.
  - Memories are combinational reads.
  - Data for an address driven at edge N is sampled at edge N+1.
- States:
  - IDLE: start=1 -> j=0; drive b_addr=0, h_addr=0, w_addr=0; go to BIAS. start is ignored in every other state.
  - BIAS: acc <= b_data; k=0; go to MAC. Addresses are held, so the first MAC sees k=0.
  - MAC: acc <= acc + sext32(w_data*h_data), using a 16-bit signed product.
    - If k==IN_DIM-1, go to CMP.
    - Otherwise k++, h_addr=k+1, w_addr=j*IN_DIM+k+1.
  - CMP:
    - If j==0 or acc > best (signed, strict): best <= acc, best_idx <= j. Ties keep the lower index.
    - If j==OUT_DIM-1, go to DONE.
    - Otherwise j++, b_addr=j+1, h_addr=0, w_addr=(j+1)*IN_DIM; go to BIAS.
  - DONE: class_out <= best_idx, max_logit <= best, done <= 1 for one cycle, busy <= 0; go to IDLE.
- Latency: OUT_DIM*(IN_DIM+2)+1 cycles from the accepted start edge to the done-high cycle. Defaults: 341.
- Arithmetic: the 32-bit accumulator wraps in two's complement; no saturation and no shift.
- Back-to-back: start sampled in the cycle after done is accepted.
- Reset mid-run: all state clears immediately; done does not pulse; class_out and max_logit read 0.

Optional Feature:
- Macro FC2_LOGIT_WR_EN.
- Defined:
  - Adds output ports logit_we (1), logit_addr ($clog2(OUT_DIM)) and logit_data (32 signed).
  - In each CMP cycle, logit_we=1, logit_addr=j, logit_data=acc. All three reset to 0.
- Undefined: these ports and their logic are absent; no other behaviour changes.

Decomposition:
- Shared package mnist_pkg: IN_DIM/OUT_DIM defaults, ACC_W=32, DATA_W=8, state encodings.
- Natural sub-module argmax_tracker:
  - Inputs: clear, valid, idx, value.
  - Outputs: best_idx, best.
  - Behaviour: strict greater-than; first valid after clear always loads.
- FSM and MAC stay in fc2_argmax.

Test Plan:
1. All h1=0, b2=[0,0,0,5,0,0,0,0,0,0] -> done at 341 cycles after start, class_out=3, max_logit=5.
2. All b2=7, h1=0 -> class_out=0, max_logit=7 (tie keeps lowest index).
3. h1 all 1, W2 row 9 all 2, other rows 0, b2=0 -> class_out=9, max_logit=64.
4. b2[j]=-100-j, h1=0 -> class_out=0, max_logit=-100 (first logit loads even when negative); h1 all 127 with W2 row 5 all -128 -> logit5=-520192 checked via FC2_LOGIT_WR_EN.
5. rst_n low for 1 cycle during MAC of neuron 4 -> outputs 0 at once, no done; a fresh start then runs case 1 correctly.
6. start held high 400 cycles -> only one run in flight; start pulsed again while busy -> ignored; a second run starts after IDLE, giving exactly 2 done pulses.
